mod_sum_seq: RTL and testbench
==============================

// Module: mod_sum_seq
// PURPOSE
//  Sequencing controller for a shared CHUNK-bit ripple adder (mod_sum).
//  Adds two W = CHUNK*NCHUNK operands one chunk per cycle, LSB chunk first.
//  A registered carry links the chunks.
//  Operands enter on a valid/ready handshake; results leave on a second one.
//  Sits between the control unit and the ALU result path.
// PARAMETERS
//  CHUNK   4  width of the shared mod_sum adder, in bits (>=1)
//  NCHUNK  4  number of chunks per operation (>=2); W = CHUNK*NCHUNK
// PORTS
//  clk           in   1  single clock; all state updates on rising edge
//  rst           in   1  synchronous, active-high reset
//  start_valid   in   1  operands a/b/cin are valid
//  start_ready   out  1  block can accept operands
//  a             in   W  operand A
//  b             in   W  operand B
//  cin           in   1  carry into chunk 0
//  result_valid  out  1  sum/cout hold the final result
//  result_ready  in   1  consumer takes the result
//  sum           out  W  result
//  cout          out  1  carry out of the top chunk
//  busy          out  1  high in RUN or DONE
// BEHAVIOUR
//  - Reset values: state=IDLE, start_ready=1, result_valid=0, sum=0, cout=0,
//    busy=0, chunk counter=0, carry register=0.
//  - FSM states: IDLE, RUN, DONE (state_t).
//  - start_ready = (state==IDLE).
//    - Operands are accepted only when start_valid && start_ready.
//    - start_valid is ignored in RUN and DONE.
//  - IDLE, on accept:
//    - latch a and b into a_q and b_q; carry_q <= cin.
//    - sum <= 0; cnt <= 0; go to RUN.
//  - RUN, every cycle:
//    - mod_sum inputs: a_q[cnt*CHUNK +: CHUNK], b_q[same slice], carry_q.
//    - sum[cnt*CHUNK +: CHUNK] <= adder sum; carry_q <= adder cout.
//    - If cnt==NCHUNK-1: cout <= adder cout and go to DONE. Otherwise cnt++.
//  - Latency: result_valid rises exactly NCHUNK cycles after the accept edge.
//  - DONE:
//    - result_valid=1; sum and cout are held stable.
//    - On result_ready, go to IDLE with result_valid=0.
//    - sum and cout keep their values until the next accept.
//  - There is no overlap: the next accept can happen no earlier than the cycle
//    after the result is taken.
//  - Arithmetic is modulo 2^W; the carry out of the top chunk appears only on
//    cout.
//  - A rst asserted in any state, including mid-RUN, forces the reset values
//    on the next edge. The partial result is discarded.
// CONFIGURATION
//  Macro MOD_SUM_SEQ_SUB_EN.
//  - Defined:
//    - adds port sub (in, 1), sampled at accept.
//    - sub=1: b_q <= ~b, carry_q <= 1, cin is ignored; result = a-b mod 2^W.
//    - cout=1 means no borrow (a>=b unsigned).
//    - sub=0: behaviour is identical to the undefined case.
//  - Undefined: there is no sub port and the block only adds.
// STRUCTURE
//  - Package mod_sum_seq_pkg holds:
//    - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}
//    - function cnt_w(n) = (n<=1) ? 1 : $clog2(n), used to size the counter.
//  - One sub-module instance: mod_sum #(.width(CHUNK)) u_chunk_add.
//    It is shared by all chunks through the cnt-indexed slices.
//  - No other sub-modules. The slice mux, counter and FSM live in this file.
// TESTING  (CHUNK=4, NCHUNK=4, W=16)
//  1. Plain add, no carry chain:
//     a=0x1234, b=0x1111, cin=0 -> sum=0x2345, cout=0.
//     result_valid exactly 4 cycles after accept.
//  2. Full carry ripple across chunks:
//     a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
//  3. Carry-in into chunk 0:
//     a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0.
//  4. Back-pressure: result_ready=0 for 3 cycles in DONE.
//     -> sum/cout/result_valid stay stable; start_ready=0.
//     -> start_valid pulses are ignored.
//     -> On result_ready=1, IDLE follows on the next cycle.
//  5. Reset mid-operation: rst=1 in the second RUN cycle.
//     -> Next cycle: IDLE, sum=0, result_valid=0, start_ready=1.
//     -> A following a=0x0001, b=0x0002 -> sum=0x0003.
//  6. With MOD_SUM_SEQ_SUB_EN:
//     sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
//     sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/mod_sum_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sum_seq_pkg
//  Purpose  : Shared types and helpers for the chunked add sequencer.
//             state_t : sequencer FSM states
//             cnt_w() : bit width of a counter that indexes n chunks
//  Revision : 1.0  initial release
// ============================================================================
package mod_sum_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A counter over n items needs at least one bit, even when n is 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : mod_sum_seq_pkg
`default_nettype wire

// File: rtl/mod_sum.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sum
//  Purpose  : Combinational ripple adder of configurable width, with carry.
//  Ports    : a, b  (in,  width)  addends
//             ci    (in,  1)      carry in
//             s     (out, width)  sum, modulo 2^width
//             co    (out, 1)      carry out
//  Revision : 1.0  initial release
// ============================================================================
module mod_sum #(
  parameter int width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             ci,
  output logic [width-1:0] s,
  output logic             co
);

  // One extra bit captures the carry out of the top position.
  logic [width:0] sum_w;

  assign sum_w = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, ci};
  assign s     = sum_w[width-1:0];
  assign co    = sum_w[width];

endmodule : mod_sum
`default_nettype wire

// File: rtl/mod_sum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sum_seq
//  Purpose  : Sequences one shared CHUNK-bit adder (mod_sum) across NCHUNK
//             chunks, LSB chunk first, so that it adds two W-bit operands with
//             W = CHUNK*NCHUNK. A registered carry links the chunks.
//  Ports    : clk, rst                    clock, synchronous active-high reset
//             start_valid/start_ready     operand handshake (a, b, cin[, sub])
//             result_valid/result_ready   result handshake (sum, cout)
//             busy                        high while in RUN or DONE
//  Config   : MOD_SUM_SEQ_SUB_EN adds input 'sub'. When sub=1 at accept, the
//             block computes a-b mod 2^W, and cout=1 means no borrow.
//  Revision : 1.0  initial release
// ============================================================================
module mod_sum_seq
  import mod_sum_seq_pkg::*;
#(
  parameter int CHUNK  = 4,
  parameter int NCHUNK = 4,
  parameter int W      = CHUNK * NCHUNK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef MOD_SUM_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int            CW   = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            start_ready_q;
  logic            result_valid_q;
  logic            busy_q;

  // Operand values captured at accept. Subtraction is a + ~b + 1.
  logic [W-1:0]    b_d;
  logic            carry_d;

`ifdef MOD_SUM_SEQ_SUB_EN
  assign b_d     = sub ? ~b : b;
  assign carry_d = sub ? 1'b1 : cin;
`else
  assign b_d     = b;
  assign carry_d = cin;
`endif

  // The one adder is shared by every chunk via the cnt-indexed slices.
  logic [CHUNK-1:0] add_a;
  logic [CHUNK-1:0] add_b;
  logic [CHUNK-1:0] add_s;
  logic             add_co;

  assign add_a = a_q[cnt_q*CHUNK +: CHUNK];
  assign add_b = b_q[cnt_q*CHUNK +: CHUNK];

  mod_sum #(.width(CHUNK)) u_chunk_add (
    .a  (add_a),
    .b  (add_b),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      carry_q        <= 1'b0;
      cnt_q          <= '0;
      sum_q          <= '0;
      cout_q         <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q           <= a;
            b_q           <= b_d;
            carry_q       <= carry_d;
            sum_q         <= '0;
            cnt_q         <= '0;
            state_q       <= RUN;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        RUN: begin
          sum_q[cnt_q*CHUNK +: CHUNK] <= add_s;
          carry_q                     <= add_co;
          if (cnt_q == LAST) begin
            cout_q         <= add_co;
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // sum/cout are left untouched here so they persist until the
          // next accept.
          if (result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          start_ready_q  <= 1'b1;
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign busy         = busy_q;

endmodule : mod_sum_seq
`default_nettype wire

// File: tb/tb_mod_sum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_sum_seq
//  Purpose  : Directed self-checking bench for mod_sum_seq (CHUNK=4, NCHUNK=4).
//             Define MOD_SUM_SEQ_SUB_EN to include the subtraction vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_sum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef MOD_SUM_SEQ_SUB_EN
  logic        sub;
`endif
  logic        result_valid;
  logic        result_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mod_sum_seq #(.CHUNK(4), .NCHUNK(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
`ifdef MOD_SUM_SEQ_SUB_EN
    .sub          (sub),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, measure latency to result_valid, check the result,
  // then take it and confirm the return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs,
                        input logic [15:0] exp_sum, input logic exp_cout);
    int n;
    a           = va;
    b           = vb;
    cin         = vc;
`ifdef MOD_SUM_SEQ_SUB_EN
    sub         = vs;
`else
    if (vs) $display("note: %s needs subtraction support", tag);
`endif
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!result_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd4);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'd0, start_ready}, 32'd1);
    chk({tag, "_idle_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_sum_held"}, {16'd0, sum}, {16'd0, exp_sum});
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    a            = '0;
    b            = '0;
    cin          = 1'b0;
`ifdef MOD_SUM_SEQ_SUB_EN
    sub          = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Plain add, carry ripple, carry-in
    run_op("add_plain", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);

    // Back-pressure in DONE: 0x8888+0x8888 = 0x1110, cout=1
    a = 16'h8888; b = 16'h8888; cin = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    n = 0;
    while (!result_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_latency", n, 32'd4);
    for (int i = 0; i < 3; i++) begin
      a = 16'h5555; b = 16'h0101; start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      chk("bp_sum", {16'd0, sum}, 32'h1110);
      chk("bp_cout", {31'd0, cout}, 32'd1);
      chk("bp_valid", {31'd0, result_valid}, 32'd1);
      chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("bp_idle_ready", {31'd0, start_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, result_valid}, 32'd0);
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);

    // Reset during the second RUN cycle
    a = 16'h1234; b = 16'h4321; cin = 1'b1;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("midrst_valid", {31'd0, result_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);

`ifdef MOD_SUM_SEQ_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("sub0_add", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_mod_sum_seq
`default_nettype wire
